i2s_master_tx: RTL
==================

# i2s_master_tx

Playback-side I2S master for the audio codec path. It generates the bit clock and LR clock from AMSCK, which puts the codec's serial port in slave mode. Each frame it pops one left and one right 24-bit sample from the two playback FIFOs (first-word-not-fall-through) and serialises them MSB-first onto the codec DAC line.

## Interface
Parameters:
- BCLK_DIV, 4: AMSCK cycles per bclk half-period; legal range >= 1. bclk = AMSCK/(2*BCLK_DIV); fs = bclk/64.

Ports:
- AMSCK  in  1  audio master clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; while low, block held in reset state.
- bclk  out  1  I2S bit clock, registered.
- lrck  out  1  I2S word select, registered; 0 = left, 1 = right.
- sdout  out  1  serial data to codec DAC, registered.
- rd_l  out  1  one-cycle pop strobe, left FIFO.
- empty_l  in  1  left FIFO empty.
- din_l  in  24  left FIFO read data, valid the cycle after rd_l.
- rd_r  out  1  one-cycle pop strobe, right FIFO.
- empty_r  in  1  right FIFO empty.
- din_r  in  24  right FIFO read data, valid the cycle after rd_r.
- underrun  out  1  one-cycle pulse when a slot starts with its FIFO empty.

## Operation
Reset values (rst=1 or en=0): bclk=0, lrck=0, sdout=0, rd_l=0, rd_r=0, underrun=0, div_cnt=0, bit_cnt=63, shift_l=0, shift_r=0.

Clock generation:
- div_cnt counts 0..BCLK_DIV-1 and wraps. bclk toggles in the cycle div_cnt wraps.
- Falling edge = cycle in which bclk goes 1->0.
- On each falling edge, bit_cnt increments modulo 64 (63 wraps to 0).

Frame:
- Two 32-bit slots: left while bit_cnt 0..31, right while bit_cnt 32..63.
- On each falling edge, lrck <= new bit_cnt[5].
- Slot position p = new bit_cnt[4:0].
- sdout = sample bit (24-p) for p = 1..24, else 0. This gives standard I2S one-bclk delay; positions 25..31 are zero padding.

Sample fetch:
- On the falling edge where bit_cnt becomes 0, sample empty_l.
  - Not empty: assert rd_l for that cycle; capture din_l into shift_l the next cycle.
  - Empty: no rd_l; pulse underrun; load underrun value (see Configuration).
- Right channel is identical at bit_cnt = 32, using empty_r/rd_r/din_r/shift_r.
- Never pop a FIFO while empty; at most one rd strobe per channel per frame.

Reset or en low mid-frame: all state returns to reset values on the next edge. No partial word is completed. The first frame after release starts cleanly at left slot 0.

## Timing
- First falling edge: 2*BCLK_DIV cycles after en=1 with rst=0. bit_cnt 63->0, lrck stays 0, rd_l pulses.
- rd_l -> sample captured: 1 cycle. Sample MSB on sdout at the next falling edge (slot position 1), 2*BCLK_DIV cycles after rd_l.
- bclk, lrck and sdout change only in falling-edge cycles (bclk also changes on rising). Codec samples on bclk rise with >= BCLK_DIV cycles of setup.
- Frame length is exactly 128*BCLK_DIV AMSCK cycles; rd_l-to-rd_l spacing is the same.
- Simultaneous events: rst takes precedence over en; en=0 takes precedence over all counter updates.

## Configuration
- I2S_TX_HOLD_EN defined: on underrun, the slot retransmits that channel's previous sample (shift register not reloaded).
- I2S_TX_HOLD_EN undefined: on underrun, the slot transmits all zeros (shift register cleared to 0).
- underrun pulses in both builds.

## Test plan
- BCLK_DIV=4, FIFOs preloaded L=0xA5F00F, R=0x5A0FF0:
  - bclk period is 8 cycles; lrck period is 512 cycles.
  - sdout on left bits 1..24 = 0xA5F00F MSB-first, then right bits 1..24 = 0x5A0FF0.
  - Bits 0 and 25..31 of each slot are 0.
- Same FIFO setup: rd_l fires exactly once, in the bclk-fall cycle with bit_cnt 63->0; rd_r once at bit_cnt 31->32; din captured one cycle later.
- empty_l=1 for one frame after L=0x123456 played:
  - No rd_l that frame; underrun pulses once.
  - Left slot is 0x000000 without the macro, 0x123456 with I2S_TX_HOLD_EN.
- Assert rst at bit_cnt=40 mid right slot: next cycle all outputs 0 and bit_cnt=63; no further rd strobes; after release the first rd_l occurs after 8 cycles.
- Drop en for 3 cycles mid-frame: same as reset; no FIFO pop lost or duplicated.
- BCLK_DIV=1: bclk = AMSCK/2, frame = 128 cycles; data is still correct with the captured sample used at position 1.

Source files
------------

// File: rtl/i2s_master_tx.sv
// rtl/i2s_master_tx.sv - I2S playback master: bclk/lrck generation and 24-bit MSB-first serialiser
// Optional macro I2S_TX_HOLD_EN: an underrun repeats the channel's previous sample instead of sending zeros.
module i2s_master_tx #(
    parameter int BCLK_DIV = 4
) (
    input  logic        AMSCK,
    input  logic        rst,
    input  logic        en,
    output logic        bclk,
    output logic        lrck,
    output logic        sdout,
    output logic        rd_l,
    input  logic        empty_l,
    input  logic [23:0] din_l,
    output logic        rd_r,
    input  logic        empty_r,
    input  logic [23:0] din_r,
    output logic        underrun
);

    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic [5:0]    bit_cnt;
    logic [23:0]   shift_l;
    logic [23:0]   shift_r;
    logic          cap_l;
    logic          cap_r;

    logic          div_wrap;
    logic          fall;
    logic [5:0]    bit_next;
    logic [4:0]    pos;
    logic [23:0]   samp_l;
    logic [23:0]   samp_r;
    logic [23:0]   samp_aligned;
    logic          ser_bit;

    // While a capture is pending the FIFO data is forwarded directly, so that
    // with BCLK_DIV=1 the freshly popped sample is already used at position 1.
    always_comb begin
        div_wrap     = (div_cnt == DIV_LAST);
        fall         = div_wrap && bclk;
        bit_next     = bit_cnt + 6'd1;
        pos          = bit_next[4:0];
        samp_l       = cap_l ? din_l : shift_l;
        samp_r       = cap_r ? din_r : shift_r;
        samp_aligned = '0;
        ser_bit      = 1'b0;
        if (pos >= 5'd1 && pos <= 5'd24) begin
            samp_aligned = (bit_next[5] ? samp_r : samp_l) << (pos - 5'd1);
            ser_bit      = samp_aligned[23];
        end
    end

    always_ff @(posedge AMSCK) begin
        if (rst || !en) begin
            div_cnt  <= '0;
            bit_cnt  <= 6'd63;
            bclk     <= 1'b0;
            lrck     <= 1'b0;
            sdout    <= 1'b0;
            rd_l     <= 1'b0;
            rd_r     <= 1'b0;
            underrun <= 1'b0;
            cap_l    <= 1'b0;
            cap_r    <= 1'b0;
            shift_l  <= '0;
            shift_r  <= '0;
        end else begin
            rd_l     <= 1'b0;
            rd_r     <= 1'b0;
            underrun <= 1'b0;
            cap_l    <= rd_l;
            cap_r    <= rd_r;
            if (cap_l) shift_l <= din_l;
            if (cap_r) shift_r <= din_r;

            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap) bclk <= ~bclk;

            if (fall) begin
                bit_cnt <= bit_next;
                lrck    <= bit_next[5];
                sdout   <= ser_bit;
                if (bit_next == 6'd0) begin
                    if (!empty_l) begin
                        rd_l <= 1'b1;
                    end else begin
                        underrun <= 1'b1;
`ifndef I2S_TX_HOLD_EN
                        shift_l  <= '0;
`endif
                    end
                end
                if (bit_next == 6'd32) begin
                    if (!empty_r) begin
                        rd_r <= 1'b1;
                    end else begin
                        underrun <= 1'b1;
`ifndef I2S_TX_HOLD_EN
                        shift_r  <= '0;
`endif
                    end
                end
            end
        end
    end

endmodule
